// File: rtl/vram_arbiter_if.sv
// CPU-side VRAM bus: level request with a one-cycle completion pulse.
// The CPU bus decode drives the request fields; the arbiter answers with ack/rdata/blocked.
interface vram_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cpu_blocked;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_blocked
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_blocked
    );
endinterface

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares the single-port 8 KB VRAM between the CPU bus and the
// PPU tile fetcher. The PPU wins whenever ppu_active is high; CPU accesses are
// either answered at once as blocked (BLOCK_MODE=1) or held off until the PPU
// releases the memory (BLOCK_MODE=0). VRAM reads are synchronous, so a CPU read
// spends one cycle issuing the address and one cycle capturing the data.
module vram_arbiter #(
    parameter bit BLOCK_MODE = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    vram_arbiter_if.slave        cpu,
    input  logic                 ppu_active,
    input  logic [12:0]          ppu_addr,
    output logic [7:0]           ppu_rdata,
    output logic [12:0]          mem_addr,
    output logic [7:0]           mem_wdata,
    output logic                 mem_wren,
    input  logic [7:0]           mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        CPU_READ,
        CPU_CAPTURE,
        CPU_WRITE,
        CPU_BLOCKED,
        PPU_OWN
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cpu_rdata_q, cpu_rdata_d;

    // Next-state and read-data capture: a read that already issued its address
    // always finishes, a write always commits, and an aborted read either
    // reports blocked or waits behind the PPU and is reissued from IDLE.
    always_comb begin
        state_d     = state_q;
        cpu_rdata_d = cpu_rdata_q;
        case (state_q)
            IDLE: begin
                if (ppu_active && cpu.cpu_req && BLOCK_MODE) begin
                    state_d = CPU_BLOCKED;
                end else if (ppu_active) begin
                    state_d = PPU_OWN;
                end else if (cpu.cpu_req) begin
                    state_d = cpu.cpu_we ? CPU_WRITE : CPU_READ;
                end
            end
            CPU_READ: begin
                if (ppu_active) begin
                    state_d = BLOCK_MODE ? CPU_BLOCKED : PPU_OWN;
                end else begin
                    state_d = CPU_CAPTURE;
                end
            end
            CPU_CAPTURE: begin
                cpu_rdata_d = mem_rdata;
                state_d     = IDLE;
            end
            CPU_WRITE: begin
                state_d = IDLE;
            end
            CPU_BLOCKED: begin
                if (!cpu.cpu_we) begin
                    cpu_rdata_d = 8'hFF;
                end
                state_d = IDLE;
            end
            PPU_OWN: begin
                if (!ppu_active) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and read-data registers; reset abandons any in-flight CPU access.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cpu_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    // Handshake and write strobe are pure state decodes, so they never glitch
    // with the CPU or PPU inputs.
    assign cpu.cpu_ack     = (state_q == CPU_WRITE) || (state_q == CPU_CAPTURE) ||
                             (state_q == CPU_BLOCKED);
    assign cpu.cpu_blocked = (state_q == CPU_BLOCKED);
    assign cpu.cpu_rdata   = cpu_rdata_q;
    assign mem_wren        = (state_q == CPU_WRITE);
    assign mem_wdata       = cpu.cpu_wdata;
    assign ppu_rdata       = mem_rdata;

    // The PPU address takes the bus as soon as ppu_active is seen, except in the
    // single committing write cycle, which the fetcher's wait state absorbs.
    assign mem_addr = ((state_q == PPU_OWN) || (ppu_active && (state_q != CPU_WRITE)))
                      ? ppu_addr : cpu.cpu_addr;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed testbench for vram_arbiter. Two instances share clock and reset:
// dut1 uses BLOCK_MODE=1, dut0 uses BLOCK_MODE=0. Each has its own VRAM model.
module tb_vram_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ppu_active1, ppu_active0;
    logic [12:0] ppu_addr;
    logic [7:0]  ppu_rdata1, ppu_rdata0;
    logic [12:0] mem_addr1, mem_addr0;
    logic [7:0]  mem_wdata1, mem_wdata0;
    logic        mem_wren1, mem_wren0;
    logic [7:0]  mem_rdata1, mem_rdata0;

    logic [7:0]  vram1 [0:8191];
    logic [7:0]  vram0 [0:8191];

    int test_count = 0;
    int fail_count = 0;

    vram_arbiter_if bus1 ();
    vram_arbiter_if bus0 ();

    always #5 clock = ~clock;

    vram_arbiter #(.BLOCK_MODE(1'b1)) dut1 (
        .clock(clock), .reset(reset), .cpu(bus1),
        .ppu_active(ppu_active1), .ppu_addr(ppu_addr), .ppu_rdata(ppu_rdata1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_wren(mem_wren1),
        .mem_rdata(mem_rdata1)
    );

    vram_arbiter #(.BLOCK_MODE(1'b0)) dut0 (
        .clock(clock), .reset(reset), .cpu(bus0),
        .ppu_active(ppu_active0), .ppu_addr(ppu_addr), .ppu_rdata(ppu_rdata0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_wren(mem_wren0),
        .mem_rdata(mem_rdata0)
    );

    // Synchronous-read VRAM models: data appears one cycle after the address.
    always @(posedge clock) begin
        mem_rdata1 <= vram1[mem_addr1];
        if (mem_wren1) vram1[mem_addr1] = mem_wdata1;
        mem_rdata0 <= vram0[mem_addr0];
        if (mem_wren0) vram0[mem_addr0] = mem_wdata0;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input bit req, input bit we,
                                 input logic [12:0] addr, input logic [7:0] wdata);
        if (port == 1) begin
            bus1.cpu_req = req; bus1.cpu_we = we;
            bus1.cpu_addr = addr; bus1.cpu_wdata = wdata;
        end else begin
            bus0.cpu_req = req; bus0.cpu_we = we;
            bus0.cpu_addr = addr; bus0.cpu_wdata = wdata;
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    initial begin
        int ack_cnt;
        int latency;

        for (int i = 0; i < 8192; i++) begin
            vram1[i] = 8'h00;
            vram0[i] = 8'h00;
        end
        vram1[13'h1805] = 8'h07;
        vram1[13'h0010] = 8'h3C;
        vram0[13'h0100] = 8'h9E;

        reset = 1'b1;
        ppu_active1 = 1'b0;
        ppu_active0 = 1'b0;
        ppu_addr = 13'h0000;
        applyStimulus(1, 1'b0, 1'b0, 13'h0000, 8'h00);
        applyStimulus(0, 1'b0, 1'b0, 13'h0000, 8'h00);

        // Reset state
        tick(); tick();
        checkOutput("rst_ack", bus1.cpu_ack, 0);
        checkOutput("rst_blocked", bus1.cpu_blocked, 0);
        checkOutput("rst_wren", mem_wren1, 0);
        checkOutput("rst_rdata", bus1.cpu_rdata, 8'h00);
        reset = 1'b0;

        // Test 1: reset held two cycles in the middle of a CPU read
        applyStimulus(1, 1'b1, 1'b0, 13'h0010, 8'h00);
        tick();
        checkOutput("t1_read_addr", mem_addr1, 13'h0010);
        checkOutput("t1_read_noack", bus1.cpu_ack, 0);
        reset = 1'b1;
        applyStimulus(1, 1'b0, 1'b0, 13'h0010, 8'h00);
        tick();
        checkOutput("t1_rst_ack_a", bus1.cpu_ack, 0);
        tick();
        checkOutput("t1_rst_ack_b", bus1.cpu_ack, 0);
        checkOutput("t1_rst_rdata", bus1.cpu_rdata, 8'h00);
        checkOutput("t1_rst_wren", mem_wren1, 0);
        reset = 1'b0;

        // Test 2: uncontended write then read back
        applyStimulus(1, 1'b1, 1'b1, 13'h1800, 8'h2A);
        tick();
        checkOutput("t2_wr_wren", mem_wren1, 1);
        checkOutput("t2_wr_addr", mem_addr1, 13'h1800);
        checkOutput("t2_wr_data", mem_wdata1, 8'h2A);
        checkOutput("t2_wr_ack", bus1.cpu_ack, 1);
        applyStimulus(1, 1'b0, 1'b1, 13'h1800, 8'h2A);
        tick();
        checkOutput("t2_wr_ack_drop", bus1.cpu_ack, 0);
        checkOutput("t2_wr_wren_drop", mem_wren1, 0);
        applyStimulus(1, 1'b1, 1'b0, 13'h1800, 8'h00);
        tick();
        checkOutput("t2_rd_ack_early", bus1.cpu_ack, 0);
        tick();
        checkOutput("t2_rd_ack", bus1.cpu_ack, 1);
        checkOutput("t2_rd_blocked", bus1.cpu_blocked, 0);
        applyStimulus(1, 1'b0, 1'b0, 13'h1800, 8'h00);
        tick();
        checkOutput("t2_rd_data", bus1.cpu_rdata, 8'h2A);
        checkOutput("t2_rd_ack_drop", bus1.cpu_ack, 0);

        // Test 3: PPU owns VRAM
        ppu_active1 = 1'b1;
        ppu_addr = 13'h1805;
        #1;
        checkOutput("t3_ppu_addr_now", mem_addr1, 13'h1805);
        tick();
        checkOutput("t3_ppu_rdata", ppu_rdata1, 8'h07);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t3_ppu_wren", mem_wren1, 0);
            tick();
        end
        ppu_active1 = 1'b0;
        tick();

        // Test 4: BLOCK_MODE=1, CPU read and write while PPU active
        ppu_active1 = 1'b1;
        applyStimulus(1, 1'b1, 1'b0, 13'h0010, 8'h00);
        tick();
        checkOutput("t4_rd_ack", bus1.cpu_ack, 1);
        checkOutput("t4_rd_blocked", bus1.cpu_blocked, 1);
        applyStimulus(1, 1'b0, 1'b0, 13'h0010, 8'h00);
        ppu_active1 = 1'b0;
        tick();
        checkOutput("t4_rd_data", bus1.cpu_rdata, 8'hFF);
        checkOutput("t4_rd_ack_drop", bus1.cpu_ack, 0);
        ppu_active1 = 1'b1;
        applyStimulus(1, 1'b1, 1'b1, 13'h0010, 8'h55);
        tick();
        checkOutput("t4_wr_ack", bus1.cpu_ack, 1);
        checkOutput("t4_wr_blocked", bus1.cpu_blocked, 1);
        checkOutput("t4_wr_wren", mem_wren1, 0);
        applyStimulus(1, 1'b0, 1'b1, 13'h0010, 8'h55);
        ppu_active1 = 1'b0;
        tick();
        checkOutput("t4_vram_kept", vram1[13'h0010], 8'h3C);
        applyStimulus(1, 1'b1, 1'b0, 13'h0010, 8'h00);
        tick(); tick();
        checkOutput("t4_rb_ack", bus1.cpu_ack, 1);
        applyStimulus(1, 1'b0, 1'b0, 13'h0010, 8'h00);
        tick();
        checkOutput("t4_rb_data", bus1.cpu_rdata, 8'h3C);

        // Test 6a: ppu_active rises during the write cycle
        applyStimulus(1, 1'b1, 1'b1, 13'h0020, 8'hA5);
        tick();
        ppu_active1 = 1'b1;
        applyStimulus(1, 1'b0, 1'b1, 13'h0020, 8'hA5);
        #1;
        checkOutput("t6_wr_wren", mem_wren1, 1);
        checkOutput("t6_wr_addr", mem_addr1, 13'h0020);
        checkOutput("t6_wr_ack", bus1.cpu_ack, 1);
        tick();
        checkOutput("t6_wr_ppu_addr", mem_addr1, 13'h1805);
        tick();
        checkOutput("t6_wr_commit", vram1[13'h0020], 8'hA5);
        ppu_active1 = 1'b0;
        tick();

        // Test 6b: ppu_active rises during the capture cycle
        applyStimulus(1, 1'b1, 1'b0, 13'h1800, 8'h00);
        tick();
        checkOutput("t6_rd_noack", bus1.cpu_ack, 0);
        tick();
        ppu_active1 = 1'b1;
        applyStimulus(1, 1'b0, 1'b0, 13'h1800, 8'h00);
        #1;
        checkOutput("t6_cap_ack", bus1.cpu_ack, 1);
        checkOutput("t6_cap_addr", mem_addr1, 13'h1805);
        tick();
        checkOutput("t6_cap_data", bus1.cpu_rdata, 8'h2A);
        tick();
        checkOutput("t6_own_ack", bus1.cpu_ack, 0);
        checkOutput("t6_own_wren", mem_wren1, 0);
        ppu_active1 = 1'b0;
        tick();

        // Test 5: BLOCK_MODE=0, PPU takes over during a CPU read
        applyStimulus(0, 1'b1, 1'b0, 13'h0100, 8'h00);
        tick();
        ppu_active0 = 1'b1;
        ack_cnt = 0;
        for (int i = 0; i < 172; i++) begin
            tick();
            if (bus0.cpu_ack) ack_cnt++;
        end
        checkOutput("t5_no_ack_stalled", ack_cnt, 0);
        ppu_active0 = 1'b0;
        latency = 99;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus0.cpu_ack) begin
                latency = i;
                break;
            end
        end
        checkOutput("t5_ack_latency", latency, 3);
        checkOutput("t5_blocked", bus0.cpu_blocked, 0);
        applyStimulus(0, 1'b0, 1'b0, 13'h0100, 8'h00);
        tick();
        checkOutput("t5_rd_data", bus0.cpu_rdata, 8'h9E);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
